// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: drives PC controls and the decode output register.
// Optional perf counters enabled by defining FETCH_SEQ_PERF_EN.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_instr,
  input  logic [31:0] fetch_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        dec_ready,
  output logic [1:0]  pc_op,
  output logic [31:0] pc_target,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
`ifdef FETCH_SEQ_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalls,
  output logic [31:0] perf_redirects,
`endif
  output logic        halted
);

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;

  logic        capture;
  logic        stall;
  logic        redir;

  // State, output register and event strobes
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    pc_op     = OP_HOLD;
    pc_target = redirect_target;
    capture   = 1'b0;
    stall     = 1'b0;
    redir     = 1'b0;
    unique case (state_q)
      S_INIT: begin
        pc_op     = OP_LOAD;
        pc_target = RESET_VECTOR;
        state_d   = S_RUN;
      end
      S_RUN: begin
        if (redirect_valid) begin
          pc_op   = OP_LOAD;
          valid_d = 1'b0;
          redir   = 1'b1;
        end else if (valid_q && !dec_ready) begin
          pc_op = OP_HOLD;
          stall = 1'b1;
        end else begin
          pc_op   = OP_INC;
          capture = 1'b1;
          valid_d = 1'b1;
          instr_d = fetch_instr;
          pc_d    = fetch_pc;
          if (fetch_instr == HALT_WORD) begin
            state_d = S_HALT;
          end
        end
      end
      S_HALT: begin
        if (redirect_valid) begin
          pc_op   = OP_LOAD;
          valid_d = 1'b0;
          redir   = 1'b1;
          state_d = S_RUN;
        end else if (valid_q && dec_ready) begin
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // State and output register flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_INIT;
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign dec_valid = valid_q;
  assign dec_instr = instr_q;
  assign dec_pc    = pc_q;
  assign halted    = (state_q == S_HALT);

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] stalls_q, stalls_d;
  logic [31:0] redirs_q, redirs_d;

  // Counter increments, wrapping naturally at 2^32
  always_comb begin
    fetched_d = fetched_q + {31'd0, capture};
    stalls_d  = stalls_q + {31'd0, stall};
    redirs_d  = redirs_q + {31'd0, redir};
  end

  // Counter flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetched_q <= '0;
      stalls_q  <= '0;
      redirs_q  <= '0;
    end else begin
      fetched_q <= fetched_d;
      stalls_q  <= stalls_d;
      redirs_q  <= redirs_d;
    end
  end

  assign perf_fetched   = fetched_q;
  assign perf_stalls    = stalls_q;
  assign perf_redirects = redirs_q;
`else
  logic unused_strobes;
  assign unused_strobes = capture ^ stall ^ redir;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a PC and instruction memory model.
// Perf counters are checked when FETCH_SEQ_PERF_EN is defined.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        dec_ready = 1'b1;
  logic [1:0]  pc_op;
  logic [31:0] pc_target;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        halted;
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalls;
  logic [31:0] perf_redirects;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] pc = 32'h0;
  logic [31:0] halt_addr = 32'hFFFF_0000;

  localparam logic [31:0] RV = 32'h0000_0100;

  fetch_sequencer #(
    .RESET_VECTOR(RV),
    .HALT_WORD(32'hFFFF_FFFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fetch_instr(fetch_instr),
    .fetch_pc(fetch_pc),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .dec_ready(dec_ready),
    .pc_op(pc_op),
    .pc_target(pc_target),
    .dec_valid(dec_valid),
    .dec_instr(dec_instr),
    .dec_pc(dec_pc),
`ifdef FETCH_SEQ_PERF_EN
    .perf_fetched(perf_fetched),
    .perf_stalls(perf_stalls),
    .perf_redirects(perf_redirects),
`endif
    .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == halt_addr) return 32'hFFFF_FFFF;
    return {a[15:0], ~a[15:0]};
  endfunction

  always @(posedge clk) begin
    case (pc_op)
      2'b01: pc <= pc + 32'd4;
      2'b10: pc <= pc_target;
      default: pc <= pc;
    endcase
  end

  assign fetch_pc    = pc;
  assign fetch_instr = imem(pc);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    dec_ready = 1'b1;
    redirect_valid = 1'b0;
    step();
    checks++;
    if (dec_valid !== 1'b0 || dec_pc !== 32'h0 || dec_instr !== 32'h0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL reset_outs got v=%b pc=%h i=%h h=%b exp 0", dec_valid, dec_pc, dec_instr, halted);
    end
    checks++;
    if (pc_op !== 2'b10 || pc_target !== RV) begin
      failures++;
      $display("FAIL reset_pcop got %b/%h exp 10/%h", pc_op, pc_target, RV);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (pc_op !== 2'b10) begin
      failures++;
      $display("FAIL init_pcop got %b exp 10", pc_op);
    end
    step();
    checks++;
    if (dec_valid !== 1'b0 || pc_op !== 2'b01) begin
      failures++;
      $display("FAIL run_first got v=%b op=%b exp v=0 op=01", dec_valid, pc_op);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dec_valid !== 1'b1 || dec_pc !== RV + 32'(4 * i) || dec_instr !== imem(RV + 32'(4 * i)) || pc_op !== 2'b01) begin
        failures++;
        $display("FAIL seq_%0d got v=%b pc=%h i=%h op=%b exp pc=%h", i, dec_valid, dec_pc, dec_instr, pc_op, RV + 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      dec_ready = 1'b0;
      #1;
      checks++;
      if (pc_op !== 2'b00 || dec_valid !== 1'b1 || dec_pc !== 32'h108) begin
        failures++;
        $display("FAIL stall_%0d got op=%b v=%b pc=%h exp 00/1/108", i, pc_op, dec_valid, dec_pc);
      end
      step();
    end
    dec_ready = 1'b1;
    #1;
    checks++;
    if (pc_op !== 2'b01 || dec_pc !== 32'h108) begin
      failures++;
      $display("FAIL stall_release got op=%b pc=%h exp 01/108", pc_op, dec_pc);
    end
    step();
    checks++;
    if (dec_valid !== 1'b1 || dec_pc !== 32'h10C || dec_instr !== imem(32'h10C)) begin
      failures++;
      $display("FAIL after_stall got v=%b pc=%h exp 1/10c", dec_valid, dec_pc);
    end
  endtask

  task automatic test_redirect_stall();
    dec_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h200;
    #1;
    checks++;
    if (pc_op !== 2'b10 || pc_target !== 32'h200) begin
      failures++;
      $display("FAIL redir_op got %b/%h exp 10/200", pc_op, pc_target);
    end
    step();
    redirect_valid = 1'b0;
    dec_ready = 1'b1;
    #1;
    checks++;
    if (dec_valid !== 1'b0 || pc_op !== 2'b01) begin
      failures++;
      $display("FAIL redir_flush got v=%b op=%b exp 0/01", dec_valid, pc_op);
    end
    step();
    checks++;
    if (dec_valid !== 1'b1 || dec_pc !== 32'h200 || dec_instr !== imem(32'h200)) begin
      failures++;
      $display("FAIL redir_target got v=%b pc=%h exp 1/200", dec_valid, dec_pc);
    end
`ifdef FETCH_SEQ_PERF_EN
    checks++;
    if (perf_fetched !== 32'd5 || perf_stalls !== 32'd3 || perf_redirects !== 32'd1) begin
      failures++;
      $display("FAIL perf got f=%0d s=%0d r=%0d exp 5/3/1", perf_fetched, perf_stalls, perf_redirects);
    end
`endif
  endtask

  task automatic test_halt();
    halt_addr = 32'h110;
    redirect_valid = 1'b1;
    redirect_target = 32'h108;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    step();
    checks++;
    if (dec_valid !== 1'b1 || dec_pc !== 32'h110 || dec_instr !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL halt_deliver got v=%b pc=%h i=%h exp 1/110/ffffffff", dec_valid, dec_pc, dec_instr);
    end
    checks++;
    if (halted !== 1'b1 || pc_op !== 2'b00) begin
      failures++;
      $display("FAIL halt_state got h=%b op=%b exp 1/00", halted, pc_op);
    end
    dec_ready = 1'b0;
    step();
    checks++;
    if (dec_valid !== 1'b1 || dec_pc !== 32'h110) begin
      failures++;
      $display("FAIL halt_hold got v=%b pc=%h exp 1/110", dec_valid, dec_pc);
    end
    dec_ready = 1'b1;
    step();
    step();
    checks++;
    if (dec_valid !== 1'b0 || halted !== 1'b1 || pc_op !== 2'b00) begin
      failures++;
      $display("FAIL halt_drain got v=%b h=%b op=%b exp 0/1/00", dec_valid, halted, pc_op);
    end
    redirect_valid = 1'b1;
    redirect_target = 32'h300;
    #1;
    checks++;
    if (pc_op !== 2'b10 || pc_target !== 32'h300) begin
      failures++;
      $display("FAIL halt_redir_op got %b/%h exp 10/300", pc_op, pc_target);
    end
    step();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b0 || dec_valid !== 1'b0) begin
      failures++;
      $display("FAIL halt_exit got h=%b v=%b exp 0/0", halted, dec_valid);
    end
    step();
    checks++;
    if (dec_valid !== 1'b1 || dec_pc !== 32'h300) begin
      failures++;
      $display("FAIL resume got v=%b pc=%h exp 1/300", dec_valid, dec_pc);
    end
  endtask

  task automatic test_async_reset();
    step();
    checks++;
    if (dec_pc !== 32'h304) begin
      failures++;
      $display("FAIL pre_reset got pc=%h exp 304", dec_pc);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (dec_valid !== 1'b0 || pc_op !== 2'b10 || halted !== 1'b0 || dec_pc !== 32'h0) begin
      failures++;
      $display("FAIL async_reset got v=%b op=%b h=%b pc=%h exp 0/10/0/0", dec_valid, pc_op, halted, dec_pc);
    end
    step();
    rst = 1'b1;
    step();
    checks++;
    if (dec_valid !== 1'b0 || pc_op !== 2'b01) begin
      failures++;
      $display("FAIL restart_run got v=%b op=%b exp 0/01", dec_valid, pc_op);
    end
    step();
    checks++;
    if (dec_valid !== 1'b1 || dec_pc !== RV) begin
      failures++;
      $display("FAIL restart_pc got v=%b pc=%h exp 1/%h", dec_valid, dec_pc, RV);
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_redirect_stall();
    test_halt();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controller for the fetch stage: drives the Program Counter's `PC_op`/`PC_in` controls and holds the fetched instruction/PC in a one-entry output register toward decode. It sequences reset-vector load, sequential fetch, back-pressure stalls, jump/branch redirects and halt. The block sits between the fetch stage (PC plus combinational instruction memory) and decode. It is the only driver of the PC control inputs.

## Interface
- `RESET_VECTOR`, 32'h0000_0000, first PC loaded after reset
- `HALT_WORD`, 32'hFFFF_FFFF, instruction encoding that halts fetch

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `fetch_instr`  in  32  instruction from fetch stage (combinational from current PC)
- `fetch_pc`  in  32  current PC from fetch stage
- `redirect_valid`  in  1  jump/branch taken this cycle
- `redirect_target`  in  32  jump/branch destination
- `dec_ready`  in  1  decode accepts output register this cycle
- `pc_op`  out  2  to `PC_op`: 00 hold, 01 PC+4, 10 load `pc_target`; 11 never driven
- `pc_target`  out  32  to `PC_in`
- `dec_valid`  out  1  output register holds a valid instruction
- `dec_instr`  out  32  registered instruction
- `dec_pc`  out  32  PC of `dec_instr`
- `halted`  out  1  high while in HALT

## Operation
- States: INIT, RUN, HALT. Reset enters INIT.
- Outputs in reset: `dec_valid`=0, `dec_instr`=0, `dec_pc`=0, `halted`=0.
  - `pc_op`/`pc_target` are combinational from state: in INIT they are 10/`RESET_VECTOR`.
- INIT:
  - Drive `pc_op`=10, `pc_target`=`RESET_VECTOR`.
  - Go to RUN next cycle. `redirect_valid` is ignored.
- RUN, priority order:
  1. `redirect_valid`=1: `pc_op`=10, `pc_target`=`redirect_target`; `dec_valid` cleared at the edge (flush). No capture this cycle.
  2. `dec_valid`=1 and `dec_ready`=0: `pc_op`=00 (stall). The output register holds.
  3. Otherwise: `pc_op`=01. Capture `fetch_instr`/`fetch_pc`, set `dec_valid`=1.
     - If the captured instruction equals `HALT_WORD`, go to HALT. The halt instruction itself is delivered to decode.
- `pc_target` = `redirect_target` whenever not in INIT. This keeps the value stable while `pc_op`≠10.
- HALT:
  - `pc_op`=00, `halted`=1.
  - `dec_valid` drops after decode accepts the pending entry. No new capture.
  - `redirect_valid`=1 drives `pc_op`=10, flushes, and returns to RUN. This is the only exit besides reset.
- Handshake: a transfer occurs on an edge with `dec_valid`=1 and `dec_ready`=1.
  - Transfer plus capture on the same edge refills the register (full throughput: one instruction per cycle).
  - A transfer with no capture clears `dec_valid`.
- Reset mid-operation: immediate return to INIT with the reset outputs above. In-flight output is discarded.

## Timing
- Reset release at edge 0 (INIT, `pc_op`=10). Edge 1: PC=`RESET_VECTOR`, state RUN. Edge 2: capture; `dec_valid`=1 with `dec_pc`=`RESET_VECTOR`.
- Redirect at edge n (PC loads target, flush). Target instruction is captured at edge n+1 and visible at n+1 when `dec_ready`=1 or the register is empty. Penalty: 1 bubble.
- Stall: `pc_op`=00 in the same cycle `dec_ready`=0 is seen with `dec_valid`=1. No instruction is dropped or duplicated.
- Simultaneous redirect and stall: redirect wins. The held entry is flushed.
- PC+4 wraps 32'hFFFF_FFFC → 0 in the PC. The sequencer does not check for this.

## Configuration
- `FETCH_SEQ_PERF_EN` defined adds the following outputs, all reset to 0, wrapping at 2^32:
  - `perf_fetched` (32): counts captures.
  - `perf_stalls` (32): counts RUN cycles with `pc_op`=00.
  - `perf_redirects` (32): counts accepted redirects.
- `FETCH_SEQ_PERF_EN` undefined: the counters and their ports are absent. All other behaviour is identical.

## Test plan
- Reset vector: `RESET_VECTOR`=32'h100, release `rst`, `dec_ready`=1. Required: `pc_op` 10,01,01…; `dec_pc` 0x100, 0x104, 0x108 on consecutive cycles from edge 2.
- Back-pressure: hold `dec_ready`=0 for 3 cycles with `dec_pc`=0x108. Required: `pc_op`=00 for those cycles; `dec_pc` stays 0x108; next accepted `dec_pc`=0x10C; no gap or repeat.
- Redirect under stall: `dec_ready`=0 and `redirect_valid`=1 with target 0x200. Required: `pc_op`=10; `dec_valid`=0 next cycle; then `dec_pc`=0x200.
- Halt: place `HALT_WORD` at 0x110. Required: the halt instruction is delivered with `dec_pc`=0x110; `halted`=1; `pc_op`=00 thereafter. A redirect to 0x300 resumes with `dec_pc`=0x300.
- Async reset mid-stream: assert `rst`=0 between edges. Required: `dec_valid`=0 and `pc_op`=10 immediately; sequence restarts from `RESET_VECTOR`.
- With `FETCH_SEQ_PERF_EN`: run the first three scenarios. Required: counters equal the exact captures, stall cycles and redirects (e.g., `perf_redirects`=1).
